// File: rtl/mult_pkg.sv
// Shared definitions for the sequential carry-save multiplier: controller state
// encoding, handshake latency constant and the full-adder cell function.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Edges from operand accept until out_valid is seen high at an edge.
    function automatic int unsigned MULT_SEQ_LAT(input int unsigned w);
        return w + 2;
    endfunction

    // Returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

endpackage

// File: rtl/csa_row.sv
// One row of WIDTH full-adder cells: an independent carry-save row, or, with
// chain_en set, a ripple-carry adder of x + y (z ignored, carry-in 0).
module csa_row
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic             chain_en,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic             cout
);

    logic       carry;
    logic       z_eff;
    logic [1:0] fa;

    // The ripple carry is a procedural variable so the chain is not a
    // feedback through the c vector.
    always_comb begin
        s     = '0;
        c     = '0;
        carry = 1'b0;
        z_eff = 1'b0;
        fa    = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            z_eff = chain_en ? carry : z[j];
            fa    = full_add(x[j], y[j], z_eff);
            s[j]  = fa[0];
            c[j]  = fa[1];
            carry = fa[1];
        end
        cout = chain_en & carry;
    end

endmodule

// File: rtl/csa_mult_sequencer.sv
// Sequential unsigned WIDTH x WIDTH multiplier: WIDTH carry-save accumulate
// cycles, one ripple resolve cycle, then a held result behind valid/ready.
module csa_mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   step;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   s_r;
    logic [WIDTH-1:0]   c_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   pp;
    logic [WIDTH-1:0]   row_s;
    logic [WIDTH-1:0]   row_c;
    logic               row_cout;
    logic               chain_en;
    logic               last_step;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign chain_en  = (state == ST_RESOLVE);
    assign last_step = (step == CNT_W'(WIDTH - 1));
    assign pp        = b_r[step] ? a_r : '0;

    csa_row #(.WIDTH(WIDTH)) u_row (
        .x        (s_r),
        .y        (c_r),
        .z        (pp),
        .chain_en (chain_en),
        .s        (row_s),
        .c        (row_c),
        .cout     (row_cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (in_valid)  state_nxt = ST_ACCUM;
            ST_ACCUM:   if (last_step) state_nxt = ST_RESOLVE;
            ST_RESOLVE:                state_nxt = ST_DONE;
            ST_DONE:    if (out_ready) state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            step    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            c_r     <= '0;
            lo_r    <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r  <= a;
                        b_r  <= b;
                        s_r  <= '0;
                        c_r  <= '0;
                        lo_r <= '0;
                        step <= '0;
                    end
                end
                // Bit 0 of the row sum is final; the rest shifts down one weight.
                ST_ACCUM: begin
                    lo_r[step] <= row_s[0];
                    s_r        <= {1'b0, row_s[WIDTH-1:1]};
                    c_r        <= row_c;
                    step       <= step + CNT_W'(1);
                end
                ST_RESOLVE: product <= {row_s, lo_r};
                default: ;
            endcase
        end
    end

endmodule
